// File: rtl/scan_mux.sv
// scan_mux: registered N-channel multiplexer with a manual mode and an
// automatic scan mode.
//
// Manual mode forwards the channel named by sel. Scan mode walks the channels
// enabled in mask, staying DWELL cycles on each one. After visiting the
// highest enabled channel it returns to the lowest, and wrap pulses on that
// return. All outputs are registered, so a sample taken at edge n shows up
// just after edge n.
//
// Ports:
//   clk        - clock; all state changes on its rising edge
//   rst        - synchronous active-high reset
//   din        - NCH packed channels; channel k is din[k*WIDTH +: WIDTH]
//   sel        - channel index used in manual mode
//   mode       - 0 = manual select, 1 = automatic scan
//   en         - block enable; when low the outputs hold and dout_valid drops
//   mask       - scan-mode channel enables; bit k includes channel k
//   dout       - selected sample (registered)
//   dout_ch    - index of the channel that drives dout
//   dout_valid - dout/dout_ch hold a legal sample
//   wrap       - one-cycle pulse when the scan pointer wraps around
module scan_mux #(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int DWELL = 1,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*WIDTH-1:0]   din,
  input  logic [SELW-1:0]        sel,
  input  logic                   mode,
  input  logic                   en,
  input  logic [NCH-1:0]         mask,
  output logic [WIDTH-1:0]       dout,
  output logic [SELW-1:0]        dout_ch,
  output logic                   dout_valid,
  output logic                   wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              empty_q, empty_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  logic [SELW-1:0]   lowIdx;
  logic [SELW-1:0]   nextIdx;
  logic              ptrOn;
  logic [SELW-1:0]   pickIdx;
  logic              pickLive;
  logic [WIDTH-1:0]  pickData;

  // Scan helpers. lowIdx is the lowest enabled channel. nextIdx is the next
  // enabled channel above the pointer, or lowIdx when no such channel exists.
  // ptrOn tells whether the current pointer channel is still enabled.
  always_comb begin
    lowIdx  = '0;
    nextIdx = '0;
    ptrOn   = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k]) begin
        lowIdx = SELW'(k);
      end
    end
    nextIdx = lowIdx;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(ptr_q))) begin
        nextIdx = SELW'(k);
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (ptr_q == SELW'(k)) begin
        ptrOn = mask[k];
      end
    end
  end

  // Next-state decision. Each branch picks the channel index to report
  // (pickIdx) and whether that index yields a legal sample (pickLive). The
  // data mux at the end of the block then fills in dout. In IDLE, dout and
  // dout_ch keep their previous values.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    empty_d  = empty_q;
    dout_d   = dout_q;
    ch_d     = ch_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    pickIdx  = ptr_q;
    pickLive = 1'b0;
    pickData = '0;

    if (!en) begin
      state_d = IDLE;
      empty_d = 1'b0;
    end else if (!mode) begin
      state_d  = MANUAL;
      empty_d  = 1'b0;
      pickIdx  = sel;
      pickLive = (int'(sel) < NCH);
      ch_d     = sel;
    end else begin
      state_d = SCAN;
      if (mask == '0) begin
        // Nothing to scan: hold the pointer. The next non-empty cycle
        // restarts from the lowest enabled channel.
        empty_d = 1'b1;
        ch_d    = ptr_q;
      end else if ((state_q != SCAN) || empty_q) begin
        empty_d  = 1'b0;
        ptr_d    = lowIdx;
        cnt_d    = '0;
        pickIdx  = lowIdx;
        pickLive = 1'b1;
        ch_d     = lowIdx;
      end else if (cnt_q == CW'(DWELL - 1)) begin
        // Dwell finished: move to the next enabled channel, using the mask
        // as it stands on this cycle.
        ptr_d    = nextIdx;
        cnt_d    = '0;
        wrap_d   = (nextIdx <= ptr_q);
        pickIdx  = nextIdx;
        pickLive = 1'b1;
        ch_d     = nextIdx;
      end else begin
        // Mid-dwell: stay on this channel even if it was masked off meanwhile.
        cnt_d    = cnt_q + 1'b1;
        pickIdx  = ptr_q;
        pickLive = ptrOn;
        ch_d     = ptr_q;
      end
    end

    for (int k = 0; k < NCH; k++) begin
      if (pickIdx == SELW'(k)) begin
        pickData = din[k*WIDTH +: WIDTH];
      end
    end

    if (state_d != IDLE) begin
      dout_d = pickLive ? pickData : '0;
    end
    valid_d = pickLive;
  end

  // The state, the scan pointer, the dwell counter and the registered
  // outputs all live in this one block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b0;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = ch_q;
  assign dout_valid = valid_q;
  assign wrap       = wrap_q;

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 1, bit width of each data channel.
REQ-002 SHALL have parameter NCH, default 4, number of input channels (2..16).
REQ-003 SHALL have parameter DWELL, default 1, cycles spent on each channel in scan mode (1..256).
REQ-004 SHALL have derived localparam SELW = clog2(NCH), minimum 1.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port din  input  NCH*WIDTH  packed channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port sel  input  SELW  channel index used in manual mode.
REQ-009 SHALL have port mode  input  1  0 = manual select, 1 = automatic scan.
REQ-010 SHALL have port en  input  1  block enable.
REQ-011 SHALL have port mask  input  NCH  scan-mode channel enable; bit k=1 includes channel k.
REQ-012 SHALL have port dout  output  WIDTH  registered selected data.
REQ-013 SHALL have port dout_ch  output  SELW  index of the channel driving dout.
REQ-014 SHALL have port dout_valid  output  1  dout/dout_ch hold a legal sample.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse when the scan pointer wraps.

Function
REQ-016 SHALL implement states IDLE, MANUAL, SCAN; next state IDLE if en=0, else MANUAL if mode=0, else SCAN.
REQ-017 SHALL register all outputs: data sampled at edge n appears on dout after edge n (1-cycle latency).
REQ-018 IDLE: dout and dout_ch hold last value; dout_valid=0; wrap=0; pointer and dwell counter hold.
REQ-019 MANUAL: each cycle dout=din[sel], dout_ch=sel, dout_valid=1 when sel<NCH.
REQ-020 MANUAL with sel>=NCH: dout=0, dout_ch=sel, dout_valid=0.
REQ-021 SCAN entry from IDLE or MANUAL: pointer loads lowest-index set bit of mask, dwell counter clears to 0.
REQ-022 SCAN: each cycle dout=din[ptr], dout_ch=ptr, dout_valid=1; dwell counter increments.
REQ-023 SCAN: when the dwell counter reaches DWELL-1, it clears and ptr advances to the next higher set mask bit, wrapping cyclically to the lowest set bit.
REQ-024 wrap SHALL pulse 1 for exactly one cycle, coincident with the first output sample after the advance, when the new ptr is <= the old ptr.
REQ-025 A single set mask bit SHALL keep ptr constant and pulse wrap every DWELL cycles.
REQ-026 mask all-zero in SCAN: dout_valid=0, dout=0, ptr holds, wrap=0; scanning resumes from lowest set bit once any bit sets.
REQ-027 mask change mid-dwell: current dwell completes; the next advance uses the mask sampled on the advance cycle.
REQ-028 Current ptr channel masked off mid-dwell: dout_valid=0 until the advance; no wrap pulse suppressed otherwise.
REQ-029 din SHALL be sampled live each cycle (not latched at dwell start).
REQ-030 DWELL=1 SHALL advance every cycle with no bubble.

Reset
REQ-031 rst=1 at a rising edge SHALL force state IDLE, ptr=0, dwell counter=0, dout=0, dout_ch=0, dout_valid=0, wrap=0.
REQ-032 rst SHALL override en, mode, and all other inputs, including mid-dwell and mid-wrap.
REQ-033 After rst deasserts, the first state decision SHALL follow REQ-016 with SCAN entry per REQ-021.

Verification
REQ-034 Manual sweep, NCH=4, WIDTH=1: one-hot din, sel 0..3 -> dout=1 one cycle later, dout_ch=sel, valid=1.
REQ-035 Manual out-of-range, NCH=3, SELW=2: sel=3 -> dout=0, dout_valid=0.
REQ-036 Scan, NCH=4, DWELL=2, mask=4'b1011: dout_ch sequence 0,0,1,1,3,3,0 with wrap=1 on the return to 0.
REQ-037 Scan, mask=0 for 3 cycles then 4'b0100 -> valid=0 for 3 cycles, then ch 2 with wrap every DWELL cycles.
REQ-038 rst asserted mid-dwell in SCAN at ptr=2 -> next cycle all outputs 0; with en=1, mode=1 after release, scan restarts at lowest set bit.
REQ-039 en dropped for 5 cycles in SCAN -> dout holds, valid=0, ptr unchanged; re-entry restarts at lowest set bit.
